mc_controller: RTL and testbench
================================

Name: mc_controller

Overview:
- Multicycle RISC-V control FSM. It sits directly upstream of the 32-bit ALU.
- Decodes the latched instruction fields and sequences FETCH/DECODE/EXECUTE/MEM/WB.
- Drives the ALU's 3-bit op code, the operand mux selects and every datapath write enable.
- Consumes the ALU Zero flag to resolve branches.

Parameters:
- RESET_STATE, S_FETCH, state entered on reset.
- MEM_WAIT_MAX, 0, 0 means wait forever on mem_ready; N>0 means a wait longer than N cycles raises timeout_o (sticky).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  instr[6:0] from IR
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU Zero flag
- mem_ready  in  1  memory data valid / write accepted this cycle
- alu_op  out  3  000 add, 001 sub, 010 and, 011 or, 100 slt, 101 sltu
- alu_src_a  out  2  00 PC, 01 OldPC, 10 regA(rs1), 11 zero
- alu_src_b  out  2  00 regB(rs2), 01 imm, 10 const 4
- imm_src  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- result_src  out  2  00 ALUOut reg, 01 mem data reg, 10 ALU result direct
- adr_src  out  1  0 PC, 1 ALUOut
- pc_write  out  1  PC load
- ir_write  out  1  IR and OldPC load
- reg_write  out  1  register file write
- mem_write  out  1  data memory write
- illegal_o  out  1  sticky illegal-instruction flag
- timeout_o  out  1  sticky memory timeout flag

Behaviour:
- Reset: state <= S_FETCH asynchronously; illegal_o=0, timeout_o=0, wait counter=0.
  - While rst_n=0, pc_write/ir_write/reg_write/mem_write are forced 0.
  - Selects take their S_FETCH values.
- Moore-style outputs decoded from state. Exceptions: pc_write in S_BRANCH, and the alu_op ALU decode, also depend on inputs.
- S_FETCH: adr_src=0, a=00, b=10, add, result_src=10.
  - Hold while mem_ready=0.
  - When mem_ready=1: ir_write=1, pc_write=1, go to S_DECODE.
- S_DECODE: a=01, b=01, imm_src=B, add (target -> ALUOut). Next state by opcode:
  - 0000011 or 0100011 -> S_MEMADR
  - 0110011 -> S_EXECR
  - 0010011 -> S_EXECI
  - 1100011 -> S_BRANCH
  - 1101111 -> S_JAL
  - 1100111 -> S_JALR1
  - 0110111 -> S_LUI
  - any other -> illegal handling
- S_MEMADR: a=10, b=01, imm_src = I for load, S for store; add.
  - funct3 != 010 is illegal.
  - Next: S_MEMRD for load, S_MEMWR for store.
- S_MEMRD: adr_src=1. Hold until mem_ready, then S_MEMWB.
- S_MEMWB: result_src=01, reg_write=1, then S_FETCH.
- S_MEMWR: adr_src=1, mem_write=1.
  - mem_write stays asserted until mem_ready, then S_FETCH.
  - Exactly one accepted write.
- S_EXECR: a=10, b=00, op from ALU decode (see below), then S_ALUWB.
- S_EXECI: a=10, b=01, imm_src=I, then S_ALUWB.
- S_ALUWB: result_src=00, reg_write=1, then S_FETCH.
- S_BRANCH: a=10, b=00, result_src=00.
  - op/take by funct3: 000 sub/Z; 001 sub/!Z; 100 slt/!Z; 101 slt/Z; 110 sltu/!Z; 111 sltu/Z; 010 and 011 illegal.
  - pc_write = take, then S_FETCH.
- S_JAL: a=01, b=10, add, result_src=00, pc_write=1, then S_ALUWB (rd = OldPC+4).
- S_JALR1: a=10, b=01, imm_src=I, add, then S_JALR2.
  - funct3 != 000 is illegal.
- S_JALR2: a=01, b=10, add, result_src=00, pc_write=1, then S_ALUWB.
- S_LUI: a=11, b=01, imm_src=U, add, then S_ALUWB.
- ALU decode:
  - R-type: 000 gives add, or sub when funct7b5=1; 111 and; 110 or; 010 slt; 011 sltu.
  - I-type: same mapping, but funct7b5 is ignored, so 000 is always add.
  - Any other funct3 (shifts, xor) is illegal.
- Memory timeout:
  - In S_FETCH, S_MEMRD and S_MEMWR, a wait counter increments each cycle mem_ready=0 and clears on state exit.
  - Reaching MEM_WAIT_MAX sets timeout_o. The FSM keeps waiting.
- Reset mid-operation: the FSM aborts immediately and the next cycle after release is S_FETCH. An in-flight mem_write drops at once.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined: an illegal encoding goes to S_TRAP.
  - illegal_o=1.
  - All enables 0.
  - The FSM stays in S_TRAP until reset.
- Undefined: an illegal encoding goes to S_FETCH as a NOP.
  - No write enable is asserted for it.
  - illegal_o still pulses sticky-high.

Decomposition:
- Package ctrl_pkg holds:
  - state enum
  - ALU op constants
  - opcode constants
  - mux-select and imm_src encodings
- Sub-module alu_dec: combinational.
  - Inputs: instruction class, funct3, funct7b5.
  - Outputs: alu_op, branch-take polarity, illegal.

Test Plan:
- Reset: rst_n=0 mid-S_MEMWR with mem_write=1 -> mem_write=0 the same cycle; state S_FETCH after release; flags 0.
- add x3,x1,x2 (funct7b5=0) then sub (funct7b5=1) with mem_ready=1 -> 4 cycles each (FETCH, DECODE, EXECR, ALUWB); alu_op 000 then 001; reg_write only in ALUWB.
- lw with mem_ready held low 3 cycles in S_MEMRD -> state holds; MEMWB one cycle after mem_ready; total 8 cycles.
- Branch sweep with zero=1: beq -> pc_write=1; bne -> pc_write=0; bge -> alu_op=100 and pc_write=1; bltu -> alu_op=101 and pc_write=0.
- jal and jalr -> pc_write in S_JAL / S_JALR2; reg_write in the following ALUWB; jalr with funct3=001 -> illegal_o=1.
- opcode 0000000, with and without ILLEGAL_TRAP_EN -> FSM stuck in S_TRAP vs. returns to S_FETCH; illegal_o=1 in both.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle RISC-V control FSM (mc_controller).
// Holds the FSM state enum, the ALU decode class, the ALU op codes, the
// opcode constants and the mux-select / immediate-format encodings.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXECR, S_EXECI,
    S_ALUWB, S_BRANCH, S_JAL, S_JALR1, S_JALR2, S_LUI, S_TRAP
  } state_t;

  // Which ALU decode table applies in the current state.
  typedef enum logic [1:0] {CLS_ADD, CLS_R, CLS_I, CLS_BR} alu_cls_t;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_SLT  = 3'b100;
  localparam logic [2:0] ALU_SLTU = 3'b101;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic ADR_PC     = 1'b0;
  localparam logic ADR_ALUOUT = 1'b1;

endpackage

// File: rtl/mc_controller_if.sv
// Control bundle between the multicycle FSM and the datapath.
// master: the controller (consumes instruction fields, Zero, mem_ready;
//         drives ALU op, mux selects, write enables and sticky flags).
// slave:  the datapath side.
interface mc_controller_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic [2:0] alu_op;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] imm_src;
  logic [1:0] result_src;
  logic       adr_src;
  logic       pc_write;
  logic       ir_write;
  logic       reg_write;
  logic       mem_write;
  logic       illegal_o;
  logic       timeout_o;

  modport master (
    input  opcode, funct3, funct7b5, zero, mem_ready,
    output alu_op, alu_src_a, alu_src_b, imm_src, result_src, adr_src,
           pc_write, ir_write, reg_write, mem_write, illegal_o, timeout_o
  );

  modport slave (
    output opcode, funct3, funct7b5, zero, mem_ready,
    input  alu_op, alu_src_a, alu_src_b, imm_src, result_src, adr_src,
           pc_write, ir_write, reg_write, mem_write, illegal_o, timeout_o
  );
endinterface

// File: rtl/alu_dec.sv
// Combinational ALU decoder.
// Ports: i_cls (decode table), i_funct3, i_funct7b5 in;
//        o_alu_op, o_take_on_nz (branch taken when Zero=0), o_illegal out.
module alu_dec
  import ctrl_pkg::*;
(
  input  alu_cls_t   i_cls,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  output logic [2:0] o_alu_op,
  output logic       o_take_on_nz,
  output logic       o_illegal
);

  // NOTE: every output gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    o_alu_op     = ALU_ADD;
    o_take_on_nz = 1'b0;
    o_illegal    = 1'b0;
    case (i_cls)
      CLS_R, CLS_I: begin
        case (i_funct3)
          // funct7b5 selects sub only for register-register ops.
          3'b000:  o_alu_op = (i_cls == CLS_R && i_funct7b5) ? ALU_SUB : ALU_ADD;
          3'b111:  o_alu_op = ALU_AND;
          3'b110:  o_alu_op = ALU_OR;
          3'b010:  o_alu_op = ALU_SLT;
          3'b011:  o_alu_op = ALU_SLTU;
          default: o_illegal = 1'b1;
        endcase
      end
      CLS_BR: begin
        case (i_funct3)
          3'b000:  o_alu_op = ALU_SUB;
          3'b001:  begin o_alu_op = ALU_SUB;  o_take_on_nz = 1'b1; end
          3'b100:  begin o_alu_op = ALU_SLT;  o_take_on_nz = 1'b1; end
          3'b101:  o_alu_op = ALU_SLT;
          3'b110:  begin o_alu_op = ALU_SLTU; o_take_on_nz = 1'b1; end
          3'b111:  o_alu_op = ALU_SLTU;
          default: o_illegal = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RISC-V control FSM sitting upstream of the 32-bit ALU.
// Sequences FETCH/DECODE/EXECUTE/MEM/WB and drives ALU op, operand selects,
// immediate format, result/address selects and all datapath write enables.
// Ports: clk, rst_n (async active-low); bus (mc_controller_if.master).
// Parameters: RESET_STATE (state entered on reset), MEM_WAIT_MAX (0 = wait
//   forever; N>0 = N consecutive stalled cycles in one wait raise timeout_o).
// Macro ILLEGAL_TRAP_EN: defined -> illegal encodings park the FSM in S_TRAP
//   until reset; undefined -> they retire as a NOP back to S_FETCH.
module mc_controller
  import ctrl_pkg::*;
#(
  parameter state_t      RESET_STATE  = S_FETCH,
  parameter int unsigned MEM_WAIT_MAX = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  mc_controller_if.master bus
);

`ifdef ILLEGAL_TRAP_EN
  localparam state_t ILL_NEXT = S_TRAP;
`else
  localparam state_t ILL_NEXT = S_FETCH;
`endif

  state_t      r_state, w_state_next;
  logic        r_illegal, r_timeout;
  logic [31:0] r_wait_cnt;
  alu_cls_t    w_cls;
  logic [2:0]  w_dec_op;
  logic        w_dec_nz, w_dec_ill;
  logic        w_ill_det, w_waiting;
  logic        w_pcw, w_irw, w_rw, w_mw;

  always_comb begin
    case (r_state)
      S_EXECR:  w_cls = CLS_R;
      S_EXECI:  w_cls = CLS_I;
      S_BRANCH: w_cls = CLS_BR;
      default:  w_cls = CLS_ADD;
    endcase
  end

  alu_dec u_alu_dec (
    .i_cls        (w_cls),
    .i_funct3     (bus.funct3),
    .i_funct7b5   (bus.funct7b5),
    .o_alu_op     (w_dec_op),
    .o_take_on_nz (w_dec_nz),
    .o_illegal    (w_dec_ill)
  );

  always_comb begin
    w_state_next   = r_state;
    w_ill_det      = 1'b0;
    w_waiting      = 1'b0;
    w_pcw          = 1'b0;
    w_irw          = 1'b0;
    w_rw           = 1'b0;
    w_mw           = 1'b0;
    bus.alu_src_a  = SRCA_PC;
    bus.alu_src_b  = SRCB_FOUR;
    bus.imm_src    = IMM_I;
    bus.result_src = RES_ALU;
    bus.adr_src    = ADR_PC;
    case (r_state)
      S_FETCH: begin
        w_waiting = 1'b1;
        if (bus.mem_ready) begin
          w_irw        = 1'b1;
          w_pcw        = 1'b1;
          w_state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        bus.alu_src_a = SRCA_OLDPC;
        bus.alu_src_b = SRCB_IMM;
        bus.imm_src   = IMM_B;
        case (bus.opcode)
          OP_LOAD, OP_STORE: w_state_next = S_MEMADR;
          OP_R:              w_state_next = S_EXECR;
          OP_I:              w_state_next = S_EXECI;
          OP_BR:             w_state_next = S_BRANCH;
          OP_JAL:            w_state_next = S_JAL;
          OP_JALR:           w_state_next = S_JALR1;
          OP_LUI:            w_state_next = S_LUI;
          default: begin
            w_ill_det    = 1'b1;
            w_state_next = ILL_NEXT;
          end
        endcase
      end
      S_MEMADR: begin
        bus.alu_src_a = SRCA_RS1;
        bus.alu_src_b = SRCB_IMM;
        bus.imm_src   = (bus.opcode == OP_STORE) ? IMM_S : IMM_I;
        if (bus.funct3 != 3'b010) begin
          w_ill_det    = 1'b1;
          w_state_next = ILL_NEXT;
        end else begin
          w_state_next = (bus.opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
        end
      end
      S_MEMRD: begin
        bus.adr_src = ADR_ALUOUT;
        w_waiting   = 1'b1;
        if (bus.mem_ready) w_state_next = S_MEMWB;
      end
      S_MEMWB: begin
        bus.result_src = RES_MEM;
        w_rw           = 1'b1;
        w_state_next   = S_FETCH;
      end
      S_MEMWR: begin
        // The write is held until the memory accepts it, then we leave, so
        // exactly one write is accepted.
        bus.adr_src = ADR_ALUOUT;
        w_mw        = 1'b1;
        w_waiting   = 1'b1;
        if (bus.mem_ready) w_state_next = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        bus.alu_src_a = SRCA_RS1;
        bus.alu_src_b = (r_state == S_EXECR) ? SRCB_RS2 : SRCB_IMM;
        bus.imm_src   = IMM_I;
        w_ill_det     = w_dec_ill;
        w_state_next  = w_dec_ill ? ILL_NEXT : S_ALUWB;
      end
      S_ALUWB: begin
        bus.result_src = RES_ALUOUT;
        w_rw           = 1'b1;
        w_state_next   = S_FETCH;
      end
      S_BRANCH: begin
        bus.alu_src_a  = SRCA_RS1;
        bus.alu_src_b  = SRCB_RS2;
        bus.result_src = RES_ALUOUT;
        w_ill_det      = w_dec_ill;
        w_pcw          = !w_dec_ill && (bus.zero ^ w_dec_nz);
        w_state_next   = w_dec_ill ? ILL_NEXT : S_FETCH;
      end
      S_JAL, S_JALR2: begin
        bus.alu_src_a  = SRCA_OLDPC;
        bus.imm_src    = IMM_J;
        bus.result_src = RES_ALUOUT;
        w_pcw          = 1'b1;
        w_state_next   = S_ALUWB;
      end
      S_JALR1: begin
        bus.alu_src_a = SRCA_RS1;
        bus.alu_src_b = SRCB_IMM;
        if (bus.funct3 != 3'b000) begin
          w_ill_det    = 1'b1;
          w_state_next = ILL_NEXT;
        end else begin
          w_state_next = S_JALR2;
        end
      end
      S_LUI: begin
        bus.alu_src_a = SRCA_ZERO;
        bus.alu_src_b = SRCB_IMM;
        bus.imm_src   = IMM_U;
        w_state_next  = S_ALUWB;
      end
      // With the trap enabled ILL_NEXT is S_TRAP itself, so the FSM parks here.
      S_TRAP:  w_state_next = ILL_NEXT;
      default: w_state_next = S_FETCH;
    endcase
  end

  // Enables are gated by rst_n so nothing writes while reset is asserted,
  // even though S_FETCH would otherwise react to mem_ready.
  assign bus.alu_op    = w_dec_op;
  assign bus.pc_write  = w_pcw & rst_n;
  assign bus.ir_write  = w_irw & rst_n;
  assign bus.reg_write = w_rw & rst_n;
  assign bus.mem_write = w_mw & rst_n;
  assign bus.illegal_o = r_illegal;
  assign bus.timeout_o = r_timeout;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RESET_STATE;
      r_illegal  <= 1'b0;
      r_timeout  <= 1'b0;
      r_wait_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_ill_det) r_illegal <= 1'b1;
      if (w_state_next != r_state) begin
        r_wait_cnt <= '0;
      end else if (w_waiting && !bus.mem_ready && r_wait_cnt != '1) begin
        r_wait_cnt <= r_wait_cnt + 32'd1;
      end
      // Flag the stalled cycle that brings the count up to the limit.
      if (MEM_WAIT_MAX != 0 && w_waiting && !bus.mem_ready &&
          (r_wait_cnt + 32'd1) >= MEM_WAIT_MAX) begin
        r_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller. Each instruction is expanded by a
// reference model into its expected per-cycle control behaviour, pushed to a
// scoreboard queue and checked by an independent negedge monitor.
module tb_mc_controller;
  import ctrl_pkg::*;

  localparam int TB_WAIT = 6;

  typedef struct packed {
    logic [63:0] tag;
    logic        mr;     // mem_ready to drive this cycle
    logic [5:0]  m;      // which selects are defined this cycle
    logic [2:0]  op;
    logic [1:0]  a;
    logic [1:0]  b;
    logic [2:0]  imm;
    logic [1:0]  res;
    logic        adr;
    logic        pcw, irw, rw, mw, ill, to;
  } cyc_t;

  localparam int M_OP = 0, M_A = 1, M_B = 2, M_IMM = 3, M_RES = 4, M_ADR = 5;

  logic clk = 1'b0;
  logic rst_n;
  mc_controller_if bus();

  mc_controller #(.RESET_STATE(S_FETCH), .MEM_WAIT_MAX(TB_WAIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  cyc_t q_exp[$];
  cyc_t plan[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic m_ill = 1'b0;
  logic m_to  = 1'b0;
  bit   trapped;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [18:0] view(input cyc_t c);
    return {c.pcw, c.irw, c.rw, c.mw, c.ill, c.to,
            c.m[M_OP]  ? c.op  : 3'b0, c.m[M_A]   ? c.a   : 2'b0,
            c.m[M_B]   ? c.b   : 2'b0, c.m[M_IMM] ? c.imm : 3'b0,
            c.m[M_RES] ? c.res : 2'b0, c.m[M_ADR] ? c.adr : 1'b0};
  endfunction

  // Monitor: one expected cycle per negedge while the scoreboard has work.
  cyc_t mon_e, mon_a;
  always @(negedge clk) begin
    if (q_exp.size() != 0) begin
      mon_e = q_exp.pop_front();
      mon_a = mon_e;
      {mon_a.op, mon_a.a, mon_a.b, mon_a.imm, mon_a.res, mon_a.adr} =
        {bus.alu_op, bus.alu_src_a, bus.alu_src_b, bus.imm_src, bus.result_src, bus.adr_src};
      {mon_a.pcw, mon_a.irw, mon_a.rw, mon_a.mw, mon_a.ill, mon_a.to} =
        {bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_write, bus.illegal_o, bus.timeout_o};
      check($sformatf("cycle %s @%0t", mon_e.tag, $time), 32'(view(mon_a)), 32'(view(mon_e)));
    end
  end

  // ---------------- reference model ----------------
  function automatic cyc_t mk(input logic [63:0] t);
    cyc_t c;
    c     = '0;
    c.tag = t;
    c.mr  = 1'($urandom);
    return c;
  endfunction

  function automatic cyc_t sel(input cyc_t c, input logic [2:0] op, input logic [1:0] a,
                               input logic [1:0] b);
    c.op = op; c.a = a; c.b = b;
    c.m[M_OP] = 1'b1; c.m[M_A] = 1'b1; c.m[M_B] = 1'b1;
    return c;
  endfunction

  task automatic put(input cyc_t c);
    c.ill = m_ill;
    c.to  = m_to;
    plan.push_back(c);
  endtask

  // n cycles of waiting with mem_ready low; the TB_WAIT-th one raises timeout.
  task automatic stall(input cyc_t c, input int n);
    for (int k = 1; k <= n; k++) begin
      c.mr = 1'b0;
      put(c);
      if (k == TB_WAIT) m_to = 1'b1;
    end
  endtask

  task automatic alu_ref(input bit is_r, input logic [2:0] f3, input logic f7,
                         output bit bad, output logic [2:0] op);
    bad = 0; op = 3'b000;
    case (f3)
      3'b000: op = (is_r && f7) ? 3'b001 : 3'b000;
      3'b111: op = 3'b010;
      3'b110: op = 3'b011;
      3'b010: op = 3'b100;
      3'b011: op = 3'b101;
      default: bad = 1;
    endcase
  endtask

  task automatic br_ref(input logic [2:0] f3, input logic z,
                        output bit bad, output logic [2:0] op, output logic take);
    bad = 0; op = 3'b000; take = 1'b0;
    case (f3)
      3'b000: begin op = 3'b001; take = z;  end
      3'b001: begin op = 3'b001; take = !z; end
      3'b100: begin op = 3'b100; take = !z; end
      3'b101: begin op = 3'b100; take = z;  end
      3'b110: begin op = 3'b101; take = !z; end
      3'b111: begin op = 3'b101; take = z;  end
      default: bad = 1;
    endcase
  endtask

  task automatic put_wb();
    cyc_t c;
    c = mk("ALUWB"); c.m[M_RES] = 1'b1; c.res = 2'b00; c.rw = 1'b1;
    put(c);
  endtask

  task automatic build(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                       input logic z, input int fst, input int mst);
    cyc_t c;
    bit bad;
    logic [2:0] op;
    logic take;
    plan.delete();
    trapped = 0;
    bad = 0;
    c = sel(mk("FETCH"), 3'b000, 2'b00, 2'b10);
    c.m[M_RES] = 1'b1; c.res = 2'b10; c.m[M_ADR] = 1'b1; c.adr = 1'b0;
    stall(c, fst);
    c.mr = 1'b1; c.pcw = 1'b1; c.irw = 1'b1;
    put(c);
    c = sel(mk("DECODE"), 3'b000, 2'b01, 2'b01);
    c.m[M_IMM] = 1'b1; c.imm = 3'b010;
    put(c);
    case (opc)
      7'b0000011, 7'b0100011: begin
        c = sel(mk("MEMADR"), 3'b000, 2'b10, 2'b01);
        c.m[M_IMM] = 1'b1; c.imm = (opc == 7'b0100011) ? 3'b001 : 3'b000;
        put(c);
        if (f3 != 3'b010) bad = 1;
        else if (opc == 7'b0000011) begin
          c = mk("MEMRD"); c.m[M_ADR] = 1'b1; c.adr = 1'b1;
          stall(c, mst);
          c.mr = 1'b1; put(c);
          c = mk("MEMWB"); c.m[M_RES] = 1'b1; c.res = 2'b01; c.rw = 1'b1;
          put(c);
        end else begin
          c = mk("MEMWR"); c.m[M_ADR] = 1'b1; c.adr = 1'b1; c.mw = 1'b1;
          stall(c, mst);
          c.mr = 1'b1; put(c);
        end
      end
      7'b0110011, 7'b0010011: begin
        alu_ref(opc == 7'b0110011, f3, f7, bad, op);
        c = sel(mk(opc == 7'b0110011 ? "EXECR" : "EXECI"), op,
                2'b10, opc == 7'b0110011 ? 2'b00 : 2'b01);
        c.m[M_OP] = !bad;
        if (opc == 7'b0010011) begin c.m[M_IMM] = 1'b1; c.imm = 3'b000; end
        put(c);
        if (!bad) put_wb();
      end
      7'b1100011: begin
        br_ref(f3, z, bad, op, take);
        c = sel(mk("BRANCH"), op, 2'b10, 2'b00);
        c.m[M_OP] = !bad; c.m[M_RES] = 1'b1; c.res = 2'b00;
        c.pcw = !bad && take;
        put(c);
      end
      7'b1101111: begin
        c = sel(mk("JAL"), 3'b000, 2'b01, 2'b10);
        c.m[M_RES] = 1'b1; c.res = 2'b00; c.pcw = 1'b1;
        put(c);
        put_wb();
      end
      7'b1100111: begin
        c = sel(mk("JALR1"), 3'b000, 2'b10, 2'b01);
        c.m[M_IMM] = 1'b1; c.imm = 3'b000;
        put(c);
        if (f3 != 3'b000) bad = 1;
        else begin
          c = sel(mk("JALR2"), 3'b000, 2'b01, 2'b10);
          c.m[M_RES] = 1'b1; c.res = 2'b00; c.pcw = 1'b1;
          put(c);
          put_wb();
        end
      end
      7'b0110111: begin
        c = sel(mk("LUI"), 3'b000, 2'b11, 2'b01);
        c.m[M_IMM] = 1'b1; c.imm = 3'b100;
        put(c);
        put_wb();
      end
      default: bad = 1;
    endcase
    if (bad) begin
      m_ill = 1'b1;
`ifdef ILLEGAL_TRAP_EN
      for (int k = 0; k < 4; k++) put(mk("TRAP"));
      trapped = 1;
`endif
    end
  endtask

  // ---------------- stimulus ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    q_exp.delete();
    m_ill = 1'b0;
    m_to  = 1'b0;
    bus.mem_ready = 1'b1;
    #1;
    check("rst_enables", 32'({bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_write}), 32'd0);
    check("rst_flags", 32'({bus.illegal_o, bus.timeout_o}), 32'd0);
    check("rst_selects", 32'({bus.alu_src_a, bus.alu_src_b, bus.result_src, bus.adr_src, bus.alu_op}),
          32'({2'b00, 2'b10, 2'b10, 1'b0, 3'b000}));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic start(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                       input logic z, input int fst, input int mst);
    build(opc, f3, f7, z, fst, mst);
    foreach (plan[i]) q_exp.push_back(plan[i]);
    bus.opcode = opc; bus.funct3 = f3; bus.funct7b5 = f7; bus.zero = z;
  endtask

  task automatic drive(input int n);
    for (int i = 0; i < n && i < plan.size(); i++) begin
      bus.mem_ready = plan[i].mr;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                     input logic z, input int fst, input int mst);
    start(opc, f3, f7, z, fst, mst);
    drive(plan.size());
    if (trapped) do_reset();
  endtask

  logic [6:0] legal_ops [8] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};

  initial begin
    rst_n = 1'b0;
    bus.opcode = '0; bus.funct3 = '0; bus.funct7b5 = 1'b0;
    bus.zero = 1'b0; bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    run(7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0);   // add
    run(7'b0110011, 3'b000, 1'b1, 1'b0, 0, 0);   // sub
    run(7'b0000011, 3'b010, 1'b0, 1'b0, 0, 3);   // lw, 3 stalls
    run(7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0);   // beq taken
    run(7'b1100011, 3'b001, 1'b0, 1'b1, 0, 0);   // bne not taken
    run(7'b1100011, 3'b101, 1'b0, 1'b1, 0, 0);   // bge taken
    run(7'b1100011, 3'b110, 1'b0, 1'b1, 0, 0);   // bltu not taken
    run(7'b1101111, 3'b000, 1'b0, 1'b0, 1, 0);   // jal
    run(7'b1100111, 3'b000, 1'b0, 1'b0, 0, 0);   // jalr
    run(7'b1100111, 3'b001, 1'b0, 1'b0, 0, 0);   // jalr illegal funct3
    run(7'b0110011, 3'b111, 1'b0, 1'b0, 0, 0);   // and, flag stays sticky
    do_reset();
    run(7'b0000000, 3'b000, 1'b0, 1'b0, 0, 0);   // illegal opcode
    run(7'b0010011, 3'b110, 1'b1, 1'b0, 0, 0);   // ori
    do_reset();

    // Reset while a store is waiting with mem_write asserted.
    start(7'b0100011, 3'b010, 1'b0, 1'b0, 0, 9);
    drive(6);
    bus.mem_ready = 1'b0;
    #1;
    check("memwr_before_reset", 32'(bus.mem_write), 32'd1);
    do_reset();

    // Waits below the limit, one split across two phases, then one at it.
    run(7'b0110111, 3'b000, 1'b0, 1'b0, TB_WAIT - 1, 0);
    run(7'b0000011, 3'b010, 1'b0, 1'b0, 3, TB_WAIT - 1);
    run(7'b0100011, 3'b010, 1'b0, 1'b0, 0, TB_WAIT);
    run(7'b0110011, 3'b010, 1'b0, 1'b0, 0, 0);
    do_reset();

    for (int n = 0; n < 300; n++) begin
      logic [6:0] opc;
      logic [2:0] f3;
      if ($urandom_range(0, 9) == 0) opc = 7'($urandom);
      else opc = legal_ops[$urandom_range(0, 7)];
      f3 = 3'($urandom);
      if ((opc == 7'b0000011 || opc == 7'b0100011) && $urandom_range(0, 3) != 0) f3 = 3'b010;
      if (opc == 7'b1100111 && $urandom_range(0, 3) != 0) f3 = 3'b000;
      run(opc, f3, 1'($urandom), 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
      if (n % 20 == 19) do_reset();
    end

    @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
